// File: rtl/midi_voice_pkg.sv
// midi_voice_pkg: shared MIDI status codes, allocator FSM states and event kinds
package midi_voice_pkg;
   localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
   localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
   localparam int NOTE_W = 8;
   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} alloc_state_t;
   typedef enum logic [1:0] {EV_ON, EV_OFF, EV_NOP} ev_kind_t;
endpackage

// File: rtl/voice_age_bank.sv
// voice_age_bank: NUM_VOICES saturating AGE_W-bit age counters
//   i_clk, i_nreset : clock, asynchronous active-low reset
//   i_clr           : per-voice clear to 0 (wins over increment)
//   i_inc           : increment every voice not being cleared
//   o_age           : current age per voice
module voice_age_bank #(
   parameter int NUM_VOICES = 8,
   parameter int AGE_W      = 4
) (
   input  logic                                i_clk,
   input  logic                                i_nreset,
   input  logic [NUM_VOICES-1:0]               i_clr,
   input  logic                                i_inc,
   output logic [NUM_VOICES-1:0][AGE_W-1:0]    o_age
);
   logic [NUM_VOICES-1:0][AGE_W-1:0] r_age;
   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_age <= '0;
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (i_clr[v])
               r_age[v] <= '0;
            else if (i_inc && r_age[v] != '1)
               r_age[v] <= r_age[v] + 1'b1;
         end
      end
   end
   assign o_age = r_age;
endmodule

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: polyphonic voice allocator between MIDI parser and DDS voice bank
//   i_clk, i_nreset        : clock, asynchronous active-low reset
//   i_ev_valid/o_ev_ready  : event handshake; o_ev_ready high only in IDLE
//   i_ev_status/note/vel   : MIDI event fields (status upper nibble decoded)
//   i_voice_idle           : per-voice envelope finished
//   o_voice_note/vel       : per-voice note/velocity, voice v at [8v+7:8v]
//   o_voice_gate/trig      : per-voice key held / one-cycle envelope restart
//   o_drop_count           : saturating count of unplaced note-ons
// Optional macro VOICE_STEAL_EN: steal oldest releasing, else oldest gated voice
module midi_voice_alloc
   import midi_voice_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int AGE_W      = 4
) (
   input  logic                           i_clk,
   input  logic                           i_nreset,
   input  logic                           i_ev_valid,
   output logic                           o_ev_ready,
   input  logic [7:0]                     i_ev_status,
   input  logic [NOTE_W-1:0]              i_ev_note,
   input  logic [7:0]                     i_ev_vel,
   input  logic [NUM_VOICES-1:0]          i_voice_idle,
   output logic [NUM_VOICES*NOTE_W-1:0]   o_voice_note,
   output logic [NUM_VOICES*8-1:0]        o_voice_vel,
   output logic [NUM_VOICES-1:0]          o_voice_gate,
   output logic [NUM_VOICES-1:0]          o_voice_trig,
   output logic [7:0]                     o_drop_count
);
   localparam int IDX_W = $clog2(NUM_VOICES);

   alloc_state_t                        r_state, w_state_next;
   ev_kind_t                            r_kind, w_kind;
   logic                                r_ready;
   logic [IDX_W-1:0]                    r_idx;
   logic [NOTE_W-1:0]                   r_note;
   logic [7:0]                          r_vel;
   logic [NUM_VOICES-1:0][NOTE_W-1:0]   r_vnote;
   logic [NUM_VOICES-1:0][7:0]          r_vvel;
   logic [NUM_VOICES-1:0]               r_vgate, r_vtrig;
   logic [NUM_VOICES-1:0]               r_match_mask, r_free_mask;
   logic [7:0]                          r_drop;
   logic [NUM_VOICES-1:0][AGE_W-1:0]    w_age;
   logic [NUM_VOICES-1:0]               w_clr;
   logic [IDX_W-1:0]                    w_match_idx, w_free_idx, w_tgt;
   logic                                w_xfer, w_cur_gate, w_cur_match, w_cur_free;
   logic                                w_commit, w_place, w_on, w_drop;
   logic                                w_unused;
   logic [3:0]                          w_hi;

   assign o_ev_ready   = r_ready;
   assign o_voice_note = r_vnote;
   assign o_voice_vel  = r_vvel;
   assign o_voice_gate = r_vgate;
   assign o_voice_trig = r_vtrig;
   assign o_drop_count = r_drop;

   assign w_xfer   = i_ev_valid && r_ready;
   assign w_commit = (r_state == COMMIT);
   assign w_hi     = i_ev_status[7:4];
   assign w_kind   = (i_ev_note == '0) ? EV_NOP :
                     (w_hi == MIDI_NOTE_ON && i_ev_vel != 8'd0) ? EV_ON :
                     (w_hi == MIDI_NOTE_OFF || w_hi == MIDI_NOTE_ON) ? EV_OFF : EV_NOP;

   // Classification of the voice under the scan pointer
   assign w_cur_gate  = r_vgate[r_idx];
   assign w_cur_match = w_cur_gate && (r_vnote[r_idx] == r_note);
   assign w_cur_free  = !w_cur_gate && i_voice_idle[r_idx];

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    w_state_next = w_xfer ? SCAN : IDLE;
         SCAN:    w_state_next = (r_idx == IDX_W'(NUM_VOICES-1)) ? COMMIT : SCAN;
         COMMIT:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Lowest-index match and free voice from the scan masks
   always_comb begin
      w_match_idx = '0;
      w_free_idx  = '0;
      for (int v = NUM_VOICES-1; v >= 0; v--) begin
         if (r_match_mask[v]) w_match_idx = IDX_W'(v);
         if (r_free_mask[v])  w_free_idx  = IDX_W'(v);
      end
   end

`ifdef VOICE_STEAL_EN
   logic             r_rel_found, r_gat_found;
   logic [IDX_W-1:0] r_rel_idx, r_gat_idx;
   logic [AGE_W-1:0] r_rel_age, r_gat_age;
   assign w_place  = 1'b1;
   assign w_tgt    = (|r_match_mask) ? w_match_idx : (|r_free_mask) ? w_free_idx :
                     r_rel_found ? r_rel_idx : r_gat_idx;
   assign w_unused = ^i_ev_status[3:0];
   // Strict '>' while scanning upward keeps ties on the lower index
   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_rel_found <= 1'b0;
         r_gat_found <= 1'b0;
         r_rel_idx   <= '0;
         r_gat_idx   <= '0;
         r_rel_age   <= '0;
         r_gat_age   <= '0;
      end else if (w_xfer) begin
         r_rel_found <= 1'b0;
         r_gat_found <= 1'b0;
      end else if (r_state == SCAN) begin
         if (!w_cur_gate && !i_voice_idle[r_idx] && (!r_rel_found || w_age[r_idx] > r_rel_age)) begin
            r_rel_found <= 1'b1;
            r_rel_idx   <= r_idx;
            r_rel_age   <= w_age[r_idx];
         end
         if (w_cur_gate && (!r_gat_found || w_age[r_idx] > r_gat_age)) begin
            r_gat_found <= 1'b1;
            r_gat_idx   <= r_idx;
            r_gat_age   <= w_age[r_idx];
         end
      end
   end
`else
   assign w_place  = (|r_match_mask) || (|r_free_mask);
   assign w_tgt    = (|r_match_mask) ? w_match_idx : w_free_idx;
   assign w_unused = ^{i_ev_status[3:0], w_age};
`endif

   assign w_on   = w_commit && (r_kind == EV_ON) && w_place;
   assign w_drop = w_commit && (r_kind == EV_ON) && !w_place;
   assign w_clr  = {{(NUM_VOICES-1){1'b0}}, w_on} << w_tgt;

   voice_age_bank #(.NUM_VOICES(NUM_VOICES), .AGE_W(AGE_W)) u_age (
      .i_clk    (i_clk),
      .i_nreset (i_nreset),
      .i_clr    (w_clr),
      .i_inc    (w_on),
      .o_age    (w_age)
   );

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_state      <= IDLE;
         r_ready      <= 1'b0;
         r_kind       <= EV_NOP;
         r_idx        <= '0;
         r_note       <= '0;
         r_vel        <= '0;
         r_vnote      <= '0;
         r_vvel       <= '0;
         r_vgate      <= '0;
         r_vtrig      <= '0;
         r_match_mask <= '0;
         r_free_mask  <= '0;
         r_drop       <= '0;
      end else begin
         r_state <= w_state_next;
         r_ready <= (w_state_next == IDLE);
         r_vtrig <= '0;
         if (w_xfer) begin
            r_kind <= w_kind;
            r_note <= i_ev_note;
            r_vel  <= i_ev_vel;
            r_idx  <= '0;
         end
         if (r_state == SCAN) begin
            r_idx               <= r_idx + 1'b1;
            r_match_mask[r_idx] <= w_cur_match;
            r_free_mask[r_idx]  <= w_cur_free;
         end
         // Released voices whose envelope finished are emptied outside COMMIT
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (!w_commit && !r_vgate[v] && i_voice_idle[v])
               r_vnote[v] <= '0;
         end
         if (w_on) begin
            r_vnote[w_tgt] <= r_note;
            r_vvel[w_tgt]  <= r_vel;
            r_vgate[w_tgt] <= 1'b1;
            r_vtrig[w_tgt] <= 1'b1;
         end
         if (w_commit && r_kind == EV_OFF)
            r_vgate <= r_vgate & ~r_match_mask;
         if (w_drop && r_drop != 8'hFF)
            r_drop <= r_drop + 8'd1;
      end
   end
endmodule

// File: tb/tb_midi_voice_alloc.sv
// tb_midi_voice_alloc: directed and random events checked against an array model of the allocator
module tb_midi_voice_alloc;
   localparam int NV = 8;
   logic          clk = 1'b0, nreset = 1'b0, ev_valid = 1'b0, ev_ready;
   logic [7:0]    ev_status = '0, ev_note = '0, ev_vel = '0, drop_count;
   logic [NV-1:0] voice_idle = '1, voice_gate, voice_trig, tg;
   logic [NV*8-1:0] voice_note, voice_vel;
   int n_chk = 0, n_pass = 0;
   int m_note[NV], m_vel[NV], m_age[NV], m_drop;
   bit m_gate[NV];

   midi_voice_alloc dut (
      .i_clk        (clk),
      .i_nreset     (nreset),
      .i_ev_valid   (ev_valid),
      .o_ev_ready   (ev_ready),
      .i_ev_status  (ev_status),
      .i_ev_note    (ev_note),
      .i_ev_vel     (ev_vel),
      .i_voice_idle (voice_idle),
      .o_voice_note (voice_note),
      .o_voice_vel  (voice_vel),
      .o_voice_gate (voice_gate),
      .o_voice_trig (voice_trig),
      .o_drop_count (drop_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         m_note[v] = 0; m_vel[v] = 0; m_age[v] = 0; m_gate[v] = 0;
      end
      m_drop = 0;
   endtask

   task automatic model_hk();
      for (int v = 0; v < NV; v++)
         if (!m_gate[v] && voice_idle[v]) m_note[v] = 0;
   endtask

`ifdef VOICE_STEAL_EN
   function automatic int oldest(input bit want_gate);
      int best = -1;
      for (int v = 0; v < NV; v++)
         if (m_gate[v] == want_gate && (want_gate || !voice_idle[v]) && (best < 0 || m_age[v] > m_age[best]))
            best = v;
      return best;
   endfunction
`endif

   task automatic model_ev(input logic [7:0] st, input logic [7:0] n, input logic [7:0] vl, output logic [NV-1:0] trig);
      int t = -1;
      bit on, off;
      trig = '0;
      on  = (n != 0) && st[7:4] == 4'h9 && vl != 0;
      off = (n != 0) && (st[7:4] == 4'h8 || (st[7:4] == 4'h9 && vl == 0));
      if (on) begin
         for (int v = 0; v < NV && t < 0; v++) if (m_gate[v] && m_note[v] == int'(n)) t = v;
         for (int v = 0; v < NV && t < 0; v++) if (!m_gate[v] && voice_idle[v]) t = v;
`ifdef VOICE_STEAL_EN
         if (t < 0) t = oldest(1'b0);
         if (t < 0) t = oldest(1'b1);
`endif
         if (t >= 0) begin
            for (int v = 0; v < NV; v++) m_age[v] = (v == t) ? 0 : (m_age[v] < 15 ? m_age[v] + 1 : 15);
            m_note[t] = int'(n); m_vel[t] = int'(vl); m_gate[t] = 1; trig[t] = 1'b1;
         end else if (m_drop < 255) m_drop++;
      end
      if (off)
         for (int v = 0; v < NV; v++) if (m_gate[v] && m_note[v] == int'(n)) m_gate[v] = 0;
   endtask

   function automatic logic [63:0] exp_note();
      logic [63:0] r = '0;
      for (int v = 0; v < NV; v++) r[8*v +: 8] = 8'(m_note[v]);
      return r;
   endfunction

   function automatic logic [63:0] exp_vel();
      logic [63:0] r = '0;
      for (int v = 0; v < NV; v++) r[8*v +: 8] = 8'(m_vel[v]);
      return r;
   endfunction

   function automatic logic [63:0] exp_gate();
      logic [63:0] r = '0;
      for (int v = 0; v < NV; v++) r[v] = m_gate[v];
      return r;
   endfunction

   // Called at a negedge with the DUT idle; returns the trig vector seen when ready comes back
   task automatic send(input logic [7:0] st, input logic [7:0] n, input logic [7:0] vl, output logic [NV-1:0] obs);
      logic [NV-1:0] et;
      int cnt = 0;
      while (!ev_ready && cnt < 100) begin @(negedge clk); cnt++; end
      if (!ev_ready) chk("ready_wait", 64'(ev_ready), 64'd1);
      ev_status = st; ev_note = n; ev_vel = vl; ev_valid = 1'b1;
      @(posedge clk);
      #1 ev_valid = 1'b0;
      model_ev(st, n, vl, et);
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!ev_ready && cnt < 100);
      obs = voice_trig;
      chk("latency", 64'(cnt), 64'(NV + 2));
      chk("trig",  64'(voice_trig), 64'(et));
      chk("gate",  64'(voice_gate), exp_gate());
      chk("vel",   voice_vel, exp_vel());
      chk("note",  voice_note, exp_note());
      chk("drop",  64'(drop_count), 64'(m_drop));
      @(negedge clk);
      model_hk();
      chk("trig_end", 64'(voice_trig), 64'd0);
      chk("note_hk",  voice_note, exp_note());
   endtask

   task automatic set_idle(input logic [NV-1:0] val);
      voice_idle = val;
      @(negedge clk);
      model_hk();
      chk("idle_hk", voice_note, exp_note());
   endtask

   initial begin
      logic [7:0] st, n, vl;
      int r;
      model_reset();
      #1;
      chk("init_note",  voice_note, 64'd0);
      chk("init_gate",  64'(voice_gate), 64'd0);
      chk("init_ready", 64'(ev_ready), 64'd0);
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      chk("ready_up", 64'(ev_ready), 64'd1);

      send(8'h90, 8'd60, 8'd100, tg);
      chk("t1_trig", 64'(tg), 64'h01);
      chk("t1_note0", 64'(voice_note[7:0]), 64'd60);

      send(8'h90, 8'd62, 8'd90, tg);
      send(8'h90, 8'd64, 8'd80, tg);
      set_idle(8'h00);
      send(8'h80, 8'd62, 8'd0, tg);
      chk("t2_gate1", 64'(voice_gate[1]), 64'd0);
      chk("t2_note1", 64'(voice_note[15:8]), 64'd62);
      set_idle(8'h02);
      chk("t2_clr1", 64'(voice_note[15:8]), 64'd0);

      send(8'h91, 8'd60, 8'd0, tg);
      chk("t3_gate0", 64'(voice_gate[0]), 64'd0);
      send(8'hB0, 8'd64, 8'd50, tg);

      send(8'h90, 8'd60, 8'd100, tg);
      send(8'h90, 8'd60, 8'd110, tg);
      chk("t4_retrig", 64'(tg), 64'h02);
      chk("t4_gates",  64'(voice_gate), 64'h06);

      ev_status = 8'h90; ev_note = 8'd70; ev_vel = 8'd5; ev_valid = 1'b1;
      @(posedge clk);
      repeat (3) @(negedge clk);
      nreset = 1'b0;
      #1;
      chk("rst_note",  voice_note, 64'd0);
      chk("rst_gate",  64'({voice_gate, voice_trig, drop_count}), 64'd0);
      chk("rst_ready", 64'(ev_ready), 64'd0);
      ev_valid = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      model_reset();
      chk("rel_ready_lo", 64'(ev_ready), 64'd0);
      @(negedge clk);
      chk("rel_ready_hi", 64'(ev_ready), 64'd1);
      chk("rel_gate",     64'(voice_gate), 64'd0);

      set_idle(8'hFF);
      for (int i = 0; i < NV; i++) send(8'h90, 8'(40 + i), 8'd100, tg);
      send(8'h90, 8'd50, 8'd100, tg);
`ifdef VOICE_STEAL_EN
      chk("t5_steal", 64'(voice_note[7:0]), 64'd50);
`else
      chk("t5_drop", 64'(drop_count), 64'd1);
`endif

      for (int k = 0; k < 200; k++) begin
         r  = int'($urandom_range(0, 9));
         st = (r < 5) ? (8'h90 | 8'($urandom_range(0, 15))) :
              (r < 8) ? (8'h80 | 8'($urandom_range(0, 15))) :
              (r == 8) ? 8'hB0 : 8'($urandom);
         n  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'(40 + $urandom_range(0, 11));
         vl = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
         if ($urandom_range(0, 3) == 0) set_idle(NV'($urandom));
         send(st, n, vl, tg);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
